uart_transmit: RTL and testbench

- 8051-style serial-port transmitter. It is the transmit half paired with the existing UART receive block, and shares the same SCON byte and div_clk (16x bit-rate tick).
- A CPU bus write to the transmit buffer address loads a byte. The byte is serialised in modes 0–3: mode 0 is a synchronous shift register; modes 1/2/3 are asynchronous 10/11-bit frames.
- A one-cycle ti pulse is raised on completion. The SCON owner latches ti as the TI flag.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_bitgen.sv | 38 +++
 rtl/uart_transmit.sv | 167 ++++++++++++++++
 tb/tb_uart_transmit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial port: FSM state encodings, SM modes,
// SCON bit positions and SFR addresses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    B9,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    MODE0,
    MODE1,
    MODE2,
    MODE3
  } sm_mode_e;

  localparam int unsigned SCON_SM_HI = 7;
  localparam int unsigned SCON_SM_LO = 6;
  localparam int unsigned SCON_SM2   = 5;
  localparam int unsigned SCON_REN   = 4;
  localparam int unsigned SCON_TB8   = 3;
  localparam int unsigned SCON_RB8   = 2;

  localparam logic [7:0] SCON_ADDR = 8'h98;
  localparam logic [7:0] SBUF_ADDR = 8'h99;

  function automatic logic has_ninth_bit(input sm_mode_e mode);
    return (mode == MODE2) || (mode == MODE3);
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_bitgen.sv
// Oversampling tick counter: bit boundary strobe and mode-0 shift clock
// (shift clock reflects the count the register will hold after this edge).
module uart_tx_bitgen #(
  parameter int unsigned OVS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic div_clk,
  output logic bit_end,
  output logic sclk_next
);

  localparam int unsigned CW = $clog2(OVS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (div_clk) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end   = run && div_clk && (cnt_q == CW'(OVS - 1));
  assign sclk_next = cnt_d[CW-1];

endmodule

// File: rtl/uart_transmit.sv
// 8051 serial-port transmitter, modes 0-3, all outputs registered.
// UART_TX_AUTO_PARITY_EN: ninth bit in modes 2/3 is even parity instead of TB8.
module uart_transmit
  import uart_pkg::*;
#(
  parameter logic [7:0]  TBUF_ADDR = SBUF_ADDR,
  parameter int unsigned OVS       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ab,
  input  logic       wrn,
  input  logic [7:0] db_w,
  input  logic [7:0] scon,
  input  logic       div_clk,
  output logic       txd,
  output logic       rxd_o,
  output logic       rxd_oe,
  output logic       ti,
  output logic       busy,
  output logic       wr_drop
);

  tx_state_e  state_q, state_d;
  sm_mode_e   mode_q, mode_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       nine_q, nine_d;
  logic       wrn_dly_q, wrn_dly_d;
  logic       txd_q, txd_d;
  logic       rxd_o_q, rxd_o_d;
  logic       rxd_oe_q, rxd_oe_d;
  logic       ti_q, ti_d;
  logic       busy_q, busy_d;
  logic       wr_drop_q, wr_drop_d;

  logic wr_req;
  logic bit_end;
  logic sclk_next;
  logic load_nine;

`ifdef UART_TX_AUTO_PARITY_EN
  logic unused_scon;
  assign unused_scon = ^{scon[5:0]};
  assign load_nine   = even_parity(db_w);
`else
  logic unused_scon;
  assign unused_scon = ^{scon[5:4], scon[2:0]};
  assign load_nine   = scon[SCON_TB8];
`endif

  uart_tx_bitgen #(
    .OVS (OVS)
  ) u_bitgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (busy_q),
    .div_clk   (div_clk),
    .bit_end   (bit_end),
    .sclk_next (sclk_next)
  );

  assign wr_req = (ab == TBUF_ADDR) && !wrn && wrn_dly_q;

  // STOP doubles as the one-clk ti cycle: async modes reach it after the stop
  // bit time, mode 0 jumps there straight from the last data bit.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    nine_d    = nine_q;
    busy_d    = busy_q;
    ti_d      = 1'b0;
    wrn_dly_d = wrn;
    wr_drop_d = wr_req && busy_q;

    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          sh_d      = db_w;
          mode_d    = sm_mode_e'(scon[SCON_SM_HI:SCON_SM_LO]);
          nine_d    = load_nine;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = (mode_d == MODE0) ? DATA : START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_d      = {1'b1, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (mode_q == MODE0) begin
              state_d = STOP;
              ti_d    = 1'b1;
            end else begin
              state_d = has_ninth_bit(mode_q) ? B9 : STOP;
            end
          end
        end
      end
      B9: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (ti_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (bit_end) begin
          ti_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rxd_oe_d = (state_d == DATA) && (mode_d == MODE0);
    rxd_o_d  = rxd_oe_d ? sh_d[0] : 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = (mode_d == MODE0) ? sclk_next : sh_d[0];
      B9:      txd_d = nine_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      nine_q    <= 1'b0;
      wrn_dly_q <= 1'b1;
      txd_q     <= 1'b1;
      rxd_o_q   <= 1'b1;
      rxd_oe_q  <= 1'b0;
      ti_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      nine_q    <= nine_d;
      wrn_dly_q <= wrn_dly_d;
      txd_q     <= txd_d;
      rxd_o_q   <= rxd_o_d;
      rxd_oe_q  <= rxd_oe_d;
      ti_q      <= ti_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign txd     = txd_q;
  assign rxd_o   = rxd_o_q;
  assign rxd_oe  = rxd_oe_q;
  assign ti      = ti_q;
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: frames in modes 0/1/2, busy writes,
// stuck strobe with SCON change, and reset mid-frame.
module tb_uart_transmit;

  localparam logic [7:0] TBUF = 8'h99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ab = 8'h00;
  logic       wrn = 1'b1;
  logic [7:0] db_w = 8'h00;
  logic [7:0] scon = 8'h00;
  logic       div_clk = 1'b0;
  logic       txd, rxd_o, rxd_oe, ti, busy, wr_drop;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned div_ph = 0;

  logic [10:0] r_bits;
  int unsigned r_ti_tick, r_ti_cnt, r_rises, r_rise_bad;
  int unsigned r_busy_bad, r_oe_bad, r_idle_bad, r_drops;
  bit          r_timeout;

  uart_transmit #(
    .TBUF_ADDR (TBUF),
    .OVS       (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ab      (ab),
    .wrn     (wrn),
    .db_w    (db_w),
    .scon    (scon),
    .div_clk (div_clk),
    .txd     (txd),
    .rxd_o   (rxd_o),
    .rxd_oe  (rxd_oe),
    .ti      (ti),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clocks, changed on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    div_ph  = (div_ph + 1) % 4;
    div_clk = (div_ph == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a write (starting at posedge+1) and observe the whole frame plus an idle tail.
  task automatic frame(input logic [7:0] d, input int unsigned hold, input bit mode0,
                       input int unsigned nbits, input int unsigned inj_tick, input bit inj_ti,
                       input int unsigned chg_tick, input logic [7:0] chg_scon);
    int unsigned ticks, idx, cyc, post, inj_cyc;
    bit seen_ti, inj_done;
    logic prev_txd;
    r_bits = '0; r_ti_tick = 0; r_ti_cnt = 0; r_rises = 0; r_rise_bad = 0;
    r_busy_bad = 0; r_oe_bad = 0; r_idle_bad = 0; r_drops = 0; r_timeout = 1'b0;
    ticks = 0; idx = 0; cyc = 0; post = 0; inj_cyc = 0; seen_ti = 0; inj_done = 0;
    ab = TBUF; db_w = d; wrn = 1'b0;
    @(posedge clk); #1;
    if (!busy) r_busy_bad++;
    if (mode0 != rxd_oe) r_oe_bad++;
    prev_txd = txd;
    while (post < 60 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == hold) wrn = 1'b1;
      if (inj_done && cyc == inj_cyc + 2) wrn = 1'b1;
      if (wr_drop) r_drops++;
      if (!seen_ti) begin
        if (div_clk) ticks++;
        if (div_clk && ticks % 16 == 8 && idx < nbits) begin
          r_bits[idx] = mode0 ? rxd_o : txd;
          idx++;
        end
        if (mode0 && txd && !prev_txd) begin
          r_rises++;
          if (ticks % 16 != 8) r_rise_bad++;
        end
        if (ti) begin
          seen_ti = 1; r_ti_tick = ticks; r_ti_cnt++;
          if (inj_ti) begin ab = TBUF; db_w = 8'h55; wrn = 1'b0; end
        end else begin
          if (!busy) r_busy_bad++;
          if (mode0 != rxd_oe) r_oe_bad++;
        end
        if (inj_tick != 0 && ticks == inj_tick && !inj_done) begin
          ab = TBUF; db_w = 8'h55; wrn = 1'b0; inj_done = 1; inj_cyc = cyc;
        end
        if (chg_tick != 0 && ticks == chg_tick) scon = chg_scon;
      end else begin
        post++;
        if (post == 2) wrn = 1'b1;
        if (ti) r_ti_cnt++;
        if (busy) r_busy_bad++;
        if (rxd_oe) r_oe_bad++;
        if (!txd || !rxd_o) r_idle_bad++;
      end
      prev_txd = txd;
    end
    r_timeout = !seen_ti;
  endtask

  task automatic check_frame(input string name, input logic [10:0] exp_bits,
                             input int unsigned exp_ti, input int unsigned exp_drops,
                             input bit mode0);
    check({name, ".timeout"}, 32'(r_timeout), 32'd0);
    check({name, ".bits"}, 32'(r_bits), 32'(exp_bits));
    check({name, ".ti_tick"}, r_ti_tick, exp_ti);
    check({name, ".ti_count"}, r_ti_cnt, 32'd1);
    check({name, ".busy_window"}, r_busy_bad, 32'd0);
    check({name, ".rxd_oe"}, r_oe_bad, 32'd0);
    check({name, ".idle_after"}, r_idle_bad, 32'd0);
    check({name, ".wr_drop"}, r_drops, exp_drops);
    if (mode0) begin
      check({name, ".sclk_rises"}, r_rises, 32'd8);
      check({name, ".sclk_phase"}, r_rise_bad, 32'd0);
    end
  endtask

  initial begin
    int unsigned t, cyc;
    logic [10:0] exp_m2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.txd", 32'(txd), 32'd1);
    check("rst.rxd_o", 32'(rxd_o), 32'd1);
    check("rst.rxd_oe", 32'(rxd_oe), 32'd0);
    check("rst.ti", 32'(ti), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.wr_drop", 32'(wr_drop), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Mode 1, A5: 0 | 1 0 1 0 0 1 0 1 | 1
    scon = 8'h40;
    frame(8'hA5, 1, 1'b0, 10, 0, 1'b0, 0, 8'h00);
    check_frame("m1", 11'h34A, 160, 0, 1'b0);

    // Mode 2, 3C with TB8=1: 0 | 0 0 1 1 1 1 0 0 | B9 | 1
`ifdef UART_TX_AUTO_PARITY_EN
    exp_m2 = 11'h478;
`else
    exp_m2 = 11'h678;
`endif
    scon = 8'h88;
    frame(8'h3C, 1, 1'b0, 11, 0, 1'b0, 0, 8'h00);
    check_frame("m2", exp_m2, 176, 0, 1'b0);

    // Mode 0, 81: rxd_o 1 0 0 0 0 0 0 1
    scon = 8'h00;
    frame(8'h81, 1, 1'b1, 8, 0, 1'b0, 0, 8'h00);
    check_frame("m0", 11'h081, 128, 0, 1'b1);

    // Busy writes mid-frame and in the ti cycle
    scon = 8'h40;
    frame(8'hA5, 1, 1'b0, 10, 40, 1'b1, 0, 8'h00);
    check_frame("busy", 11'h34A, 160, 2, 1'b0);

    // Stuck strobe for 20 clk, SCON switched to mode 3/TB8 mid-frame
    scon = 8'h40;
    frame(8'hA5, 20, 1'b0, 10, 0, 1'b0, 50, 8'hC8);
    check_frame("stuck", 11'h34A, 160, 0, 1'b0);
    scon = 8'h40;

    // Reset during DATA bit 3 (ticks 64..79)
    ab = TBUF; db_w = 8'hA5; wrn = 1'b0;
    @(posedge clk); #1;
    wrn = 1'b1;
    t = 0; cyc = 0;
    while (t < 70 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (div_clk) t++;
    end
    check("rstmid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid.txd", 32'(txd), 32'd1);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.ti", 32'(ti), 32'd0);
    repeat (80) @(posedge clk);
    #1;
    check("rstmid.abandoned", 32'({busy, ti, txd}), 32'b001);
    frame(8'h0F, 1, 1'b0, 10, 0, 1'b0, 0, 8'h00);
    check_frame("after_rst", 11'h21E, 160, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
